// File: rtl/sevenseg_capture_pkg.sv
// Shared 7-segment definitions: active-low hex patterns, blank pattern and the
// capture FSM state type. Also used by the hex encoder.
package sevenseg_capture_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_OFFER = 1'b1
  } cap_state_e;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational inverse of the active-low hex encoder for one digit.
module sevenseg_decode
  import sevenseg_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  always_comb begin
    // NOTE: every output gets a default before the search loop so no path leaves one unassigned (no latch).
    nibble = 4'h0;
    blank  = (seg == SEG_BLANK);
    err    = (seg != SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        nibble = 4'(i);
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Captures a settled multi-digit 7-segment display and offers it once per change
// over a valid/ready handshake. Optional error counter: SEVENSEG_CAP_ERRCNT_EN.
module sevenseg_capture
  import sevenseg_capture_pkg::*;
#(
  parameter int NDIG       = 6,
  parameter int STABLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7*NDIG-1:0]    seg_in,
  output logic [4*NDIG-1:0]    out_value,
  output logic [NDIG-1:0]      out_blank,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          err_count
);

  localparam int         SW     = 7 * NDIG;
  localparam logic [7:0] STABLE = 8'(STABLE_CYC);

  logic [SW-1:0]     seg_q;
  logic [SW-1:0]     seg_prev;
  logic [SW-1:0]     offer_pat;
  logic [SW-1:0]     last_pat;
  logic [7:0]        stable_cnt;
  logic [7:0]        cnt_nxt;
  logic              delivered;
  logic              offer_go;
  cap_state_e        state;

  logic [4*NDIG-1:0] dec_value;
  logic [NDIG-1:0]   dec_blank;
  logic [NDIG-1:0]   dec_err;

  for (genvar g = 0; g < NDIG; g++) begin : g_dec
    sevenseg_decode u_dec (
      .seg    (seg_q[7*g +: 7]),
      .nibble (dec_value[4*g +: 4]),
      .blank  (dec_blank[g]),
      .err    (dec_err[g])
    );
  end

  always_comb begin
    if (seg_q != seg_prev)       cnt_nxt = 8'd0;
    else if (stable_cnt >= STABLE) cnt_nxt = STABLE;
    else                          cnt_nxt = stable_cnt + 8'd1;
  end

  // Offer on the edge the counter reaches the threshold, so the sample that
  // settled is the one that gets latched.
  assign offer_go = (state == ST_WAIT) && (cnt_nxt == STABLE) &&
                    (!delivered || (seg_q != last_pat));

  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      seg_q      <= '1;
      seg_prev   <= '1;
      offer_pat  <= '1;
      last_pat   <= '1;
      stable_cnt <= 8'd0;
      delivered  <= 1'b0;
      state      <= ST_WAIT;
      out_valid  <= 1'b0;
      out_value  <= '0;
      out_blank  <= '0;
      out_err    <= 1'b0;
    end else begin
      seg_q      <= seg_in;
      seg_prev   <= seg_q;
      stable_cnt <= cnt_nxt;
      case (state)
        ST_WAIT: begin
          if (offer_go) begin
            state     <= ST_OFFER;
            out_valid <= 1'b1;
            offer_pat <= seg_q;
            out_value <= dec_value;
            out_blank <= dec_blank;
            out_err   <= |dec_err;
          end
        end
        ST_OFFER: begin
          if (out_ready) begin
            state     <= ST_WAIT;
            out_valid <= 1'b0;
            last_pat  <= offer_pat;
            delivered <= 1'b1;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

`ifdef SEVENSEG_CAP_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      err_cnt_q <= 16'd0;
    else if ((state == ST_OFFER) && out_ready && out_err && (err_cnt_q != 16'hFFFF))
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed self-checking bench for sevenseg_capture (default NDIG=6, STABLE_CYC=4).
module tb_sevenseg_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [41:0] seg_in;
  logic [23:0] out_value;
  logic [5:0]  out_blank;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  logic [6:0] tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  sevenseg_capture dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .out_value (out_value),
    .out_blank (out_blank),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] enc(input logic [23:0] v);
    logic [41:0] r;
    logic [3:0]  d;
    r = '0;
    for (int k = 0; k < 6; k++) begin
      d = v[4*k +: 4];
      r[7*k +: 7] = tab[d];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
  endtask

  // Counts edges until out_valid is seen; -1 when the budget runs out.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    seg_in = enc(24'h123456);
    do_reset();
    checks++;
    if ({out_valid, out_value, out_blank, out_err, err_count} !== 48'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b value=%h blank=%b err=%b errcnt=%0d, need all zero",
               out_valid, out_value, out_blank, out_err, err_count);
    end
  endtask

  task automatic test_latency_zero();
    int n;
    do_reset();
    reset = 1'b0;
    seg_in = enc(24'h000000);
    wait_valid(n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL latency_zero: valid at edge %0d, need 6", n);
    end
    checks++;
    if ({out_value, out_blank, out_err} !== 31'd0) begin
      errors++;
      $display("FAIL zero_offer: got value=%h blank=%b err=%b, need 000000/0/0", out_value, out_blank, out_err);
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_ack: valid=%b after handshake, need 0", out_valid);
    end
  endtask

  task automatic test_hold_and_no_reoffer();
    int n;
    logic bad;
    do_reset();
    reset = 1'b0;
    seg_in = enc(24'h3710AF);
    wait_valid(n);
    checks++;
    if (n !== 6 || out_value !== 24'h3710AF) begin
      errors++;
      $display("FAIL hold_offer: edge %0d value=%h, need edge 6 value 3710af", n, out_value);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_value !== 24'h3710AF) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_stall: offer dropped or changed while ready low, now valid=%b value=%h", out_valid, out_value);
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_ack: valid=%b after handshake, need 0", out_valid);
    end
    out_ready = 1'b1;  // ready in WAIT must be ignored
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    out_ready = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_reoffer: unchanged input re-offered (valid=1 seen), need valid=0");
    end
  endtask

  task automatic test_toggle();
    logic bad;
    do_reset();
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seg_in = enc((i % 4) < 2 ? 24'h000000 : 24'h000001);
      tick();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL toggle: valid seen during unstable input, need never");
    end
  endtask

  task automatic test_error();
    int n;
    logic [41:0] p;
    logic [15:0] exp_cnt;
    do_reset();
    reset = 1'b0;
    p = enc(24'h000000);
    p[20:14] = 7'b1010101;
    seg_in = p;
    wait_valid(n);
    checks++;
    if (n !== 6 || out_err !== 1'b1 || out_value !== 24'h000000 || out_blank !== 6'b0) begin
      errors++;
      $display("FAIL err_offer: edge %0d err=%b value=%h blank=%b, need 6/1/000000/000000", n, out_err, out_value, out_blank);
    end
    handshake();
`ifdef SEVENSEG_CAP_ERRCNT_EN
    exp_cnt = 16'd1;
`else
    exp_cnt = 16'd0;
`endif
    checks++;
    if (err_count !== exp_cnt) begin
      errors++;
      $display("FAIL err_count: got %0d, need %0d", err_count, exp_cnt);
    end
  endtask

  task automatic test_blank();
    int n;
    logic [41:0] p;
    do_reset();
    reset = 1'b0;
    p = enc(24'h012345);
    p[41:35] = 7'b1111111;
    seg_in = p;
    wait_valid(n);
    checks++;
    if (n !== 6 || out_blank !== 6'b100000 || out_value !== 24'h012345 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL blank_digit: edge %0d blank=%b value=%h err=%b, need 6/100000/012345/0", n, out_blank, out_value, out_err);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic bad;
    do_reset();
    reset = 1'b0;
    seg_in = enc(24'h3710AF);
    wait_valid(n);
    tick();
    seg_in = enc(24'h111111);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_value !== 24'h3710AF) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL b2b_hold: offer changed during OFFER, now valid=%b value=%h, need 1/3710af", out_valid, out_value);
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: valid=%b right after handshake, need 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_value !== 24'h111111) begin
      errors++;
      $display("FAIL b2b_next: valid=%b value=%h, need 1/111111", out_valid, out_value);
    end
  endtask

  task automatic test_reset_mid_offer();
    int n;
    do_reset();
    reset = 1'b0;
    seg_in = enc(24'hC0FFEE);
    wait_valid(n);
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_drop: valid=%b after reset edge, need 0", out_valid);
    end
    reset = 1'b0;
    wait_valid(n);
    checks++;
    if (n !== 6 || out_value !== 24'hC0FFEE) begin
      errors++;
      $display("FAIL rst_reoffer: edge %0d value=%h, need 6/c0ffee", n, out_value);
    end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    seg_in = '1;
    test_reset();
    test_latency_zero();
    test_hold_and_no_reoffer();
    test_toggle();
    test_error();
    test_blank();
    test_back_to_back();
    test_reset_mid_offer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

Interface
REQ-001 The module SHALL have a parameter NDIG, default 6: the number of 7-segment digits captured.
REQ-002 The module SHALL have a parameter STABLE_CYC, default 4: the number of consecutive unchanged samples required before an offer; legal range 1..255.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port seg_in, input, 7*NDIG bits: active-low segment patterns, DE1-SoC ordering; digit k occupies [7k+6:7k].
REQ-006 Port out_value, output, 4*NDIG bits: decoded nibbles; digit k occupies [4k+3:4k].
REQ-007 Port out_blank, output, NDIG bits: per-digit flag, 1 when the pattern is all segments off (7'b1111111).
REQ-008 Port out_err, output, 1 bit: 1 when any digit in the offer is an unrecognised pattern.
REQ-009 Port out_valid, output, 1 bit: an offer is pending.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the offer.
REQ-011 Port err_count, output, 16 bits: count of erroneous offers (see Configuration).

Function
REQ-012 seg_in SHALL pass through one input register; all decode SHALL act on the registered copy.
REQ-013 Decode SHALL be the exact inverse of the team's active-low hex patterns: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F.
REQ-014 A blank pattern SHALL decode to nibble 0 with out_blank[k]=1; any other unlisted pattern SHALL decode to nibble 0 and set out_err.
REQ-015 An 8-bit stability counter SHALL reset to 0 when the registered sample differs from the previous sample; otherwise it SHALL increment, saturating at STABLE_CYC.
REQ-016 The FSM SHALL have two states, WAIT and OFFER.
REQ-017 WAIT->OFFER SHALL occur when the counter equals STABLE_CYC and the sample differs from the last delivered pattern, or when no pattern has been delivered since reset; out_value, out_blank and out_err SHALL latch on that edge.
REQ-018 Latency: out_valid SHALL rise on the (STABLE_CYC+2)th rising edge after seg_in takes a new constant value.
REQ-019 In OFFER, out_valid=1 and all offer outputs SHALL hold constant regardless of seg_in activity.
REQ-020 OFFER->WAIT SHALL occur on the edge where out_ready=1; the sample is recorded as last delivered, and out_valid=0 from the next cycle.
REQ-021 An unchanged input SHALL never be re-offered after delivery.
REQ-022 Input changes during OFFER SHALL still update the stability counter, so a settled new value is offered on the cycle after the handshake.
REQ-023 out_ready while in WAIT SHALL be ignored.

Reset
REQ-024 On reset: state=WAIT, counter=0, the delivered flag cleared, out_valid=0, out_value=0, out_blank=0, out_err=0, err_count=0, input register=all ones.
REQ-025 Reset during OFFER SHALL drop the offer without a handshake; a stable input SHALL be re-offered afterwards.

Configuration
REQ-026 With SEVENSEG_CAP_ERRCNT_EN defined, err_count SHALL increment on each accepted offer with out_err=1, saturating at 16'hFFFF.
REQ-027 Without SEVENSEG_CAP_ERRCNT_EN, err_count SHALL be tied to 0 and the counter logic SHALL be absent.

Structure
REQ-028 A shared package SHALL hold the 16 segment-pattern constants, the blank pattern, and the FSM state enum, reused by the existing hex encoder.
REQ-029 One sub-module, sevenseg_decode (7-bit pattern -> nibble, blank, err; combinational), SHALL be instantiated NDIG times.

Verification
REQ-030 Reset, then seg_in all 1000000 held -> out_valid rises at edge 6, out_value=24'h000000, out_blank=0, out_err=0.
REQ-031 Encoded 24'h3710AF held, out_ready low for 10 cycles -> valid and value held; ready pulse -> valid low next cycle and no re-offer.
REQ-032 Digit 0 toggling 0/1 every 2 cycles -> out_valid never asserts.
REQ-033 Digit 2=1010101 with others 0 -> out_err=1, out_value=0; err_count=1 after handshake with the macro defined, 0 without it.
REQ-034 Input changed to 24'h111111 during OFFER of 24'h3710AF -> offer holds; after handshake, 24'h111111 is offered the next cycle.
REQ-035 Reset asserted mid-OFFER with the input unchanged -> out_valid=0 next edge, and the same value is re-offered 6 edges after reset deasserts.
